// File: rtl/conversor_bcd_pkg.sv
// Shared definitions for the binary-to-BCD display converter:
// FSM encoding, conversion width, saturation constants.
package conversor_bcd_pkg;

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        CARREGA = 2'd1,
        DESLOCA = 2'd2,
        FIM     = 2'd3
    } estado_t;

    localparam int BITS_CONV     = 14;
    localparam int LIMITE_PADRAO = 9999;
    localparam int N_DIGITOS     = 4;
    localparam int CONT_W        = 5;

    localparam logic [3:0] DIGITO_SAT     = 4'd9;
    localparam logic [3:0] LIMIAR_AJUSTE  = 4'd5;
    localparam logic [3:0] VALOR_AJUSTE   = 4'd3;

    function automatic logic [4*N_DIGITOS-1:0] digitos_saturados();
        return {N_DIGITOS{DIGITO_SAT}};
    endfunction

endpackage

// File: rtl/conversor_bcd_if.sv
// Producer-side bus of the converter: result word in, display digits and status out.
interface conversor_bcd_if #(
    parameter int LARGURA = 32
);
    logic                      escrever;
    logic signed [LARGURA-1:0] entrada;
    logic [3:0]                setseg1;
    logic [3:0]                setseg2;
    logic [3:0]                setseg3;
    logic [3:0]                setseg4;
    logic                      negativo;
    logic                      estouro;
    logic                      ocupado;
    logic                      pronto;

    modport master (
        output escrever, entrada,
        input  setseg1, setseg2, setseg3, setseg4,
        input  negativo, estouro, ocupado, pronto
    );

    modport slave (
        input  escrever, entrada,
        output setseg1, setseg2, setseg3, setseg4,
        output negativo, estouro, ocupado, pronto
    );
endinterface

// File: rtl/conversor_bcd_ajusta_bcd.sv
// Add-3 correction for one BCD digit, applied before each double-dabble shift.
module ajusta_bcd
    import conversor_bcd_pkg::*;
(
    input  logic [3:0] digito_i,
    output logic [3:0] digito_o
);
    assign digito_o = (digito_i >= LIMIAR_AJUSTE) ? (digito_i + VALOR_AJUSTE) : digito_i;
endmodule

// File: rtl/conversor_bcd.sv
// Signed ALU result to four BCD digits with sign and overflow flags,
// converted serially by double-dabble; display outputs change only at the end.
module conversor_bcd
    import conversor_bcd_pkg::*;
#(
    parameter int LARGURA = 32,
    parameter int LIMITE  = LIMITE_PADRAO
) (
    input  logic             clock,
    input  logic             reseta,
    conversor_bcd_if.slave   bus
);

    estado_t estado_q, estado_d;

    logic signed [LARGURA-1:0]  entrada_q;
    logic [LARGURA:0]           magnitude;
    logic                       sinal;
    logic                       satura;

    logic [BITS_CONV-1:0]       bin_q;
    logic [4*N_DIGITOS-1:0]     bcd_q;
    logic [4*N_DIGITOS-1:0]     bcd_aj;
    logic [CONT_W-1:0]          cont_q;
    logic                       neg_q;
    logic                       sat_q;
    logic                       ultimo_desloc;

    logic [4*N_DIGITOS-1:0]     saida_q;
    logic                       negativo_q;
    logic                       estouro_q;
    logic                       pronto_q;

    logic                       ocupado;
    logic                       carrega_saida;

    // Magnitude is one bit wider than the input so the most negative value negates cleanly.
    assign sinal     = entrada_q[LARGURA-1];
    assign magnitude = sinal ? (~{sinal, entrada_q} + 1'b1) : {sinal, entrada_q};
    assign satura    = magnitude > (LARGURA+1)'(LIMITE);

    assign ultimo_desloc = (cont_q == CONT_W'(BITS_CONV - 1));

    generate
        for (genvar gi = 0; gi < N_DIGITOS; gi++) begin : g_ajuste
            ajusta_bcd u_ajusta (
                .digito_i (bcd_q [4*gi +: 4]),
                .digito_o (bcd_aj[4*gi +: 4])
            );
        end
    endgenerate

    always_ff @(posedge clock or negedge reseta) begin
        if (!reseta) begin
            estado_q <= OCIOSO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            OCIOSO:  if (bus.escrever) estado_d = CARREGA;
            CARREGA: estado_d = satura ? FIM : DESLOCA;
            DESLOCA: if (ultimo_desloc) estado_d = FIM;
            FIM:     estado_d = OCIOSO;
            default: estado_d = OCIOSO;
        endcase
    end

    always_comb begin
        ocupado       = (estado_q != OCIOSO);
        carrega_saida = (estado_q == FIM);
    end

    always_ff @(posedge clock or negedge reseta) begin
        if (!reseta) begin
            entrada_q  <= '0;
            bin_q      <= '0;
            bcd_q      <= '0;
            cont_q     <= '0;
            neg_q      <= 1'b0;
            sat_q      <= 1'b0;
            saida_q    <= '0;
            negativo_q <= 1'b0;
            estouro_q  <= 1'b0;
            pronto_q   <= 1'b0;
        end else begin
            pronto_q <= carrega_saida;
            case (estado_q)
                OCIOSO: begin
                    if (bus.escrever) entrada_q <= bus.entrada;
                end
                CARREGA: begin
                    neg_q  <= sinal;
                    sat_q  <= satura;
                    bin_q  <= magnitude[BITS_CONV-1:0];
                    bcd_q  <= '0;
                    cont_q <= '0;
                end
                DESLOCA: begin
                    bcd_q  <= {bcd_aj[4*N_DIGITOS-2:0], bin_q[BITS_CONV-1]};
                    bin_q  <= {bin_q[BITS_CONV-2:0], 1'b0};
                    cont_q <= cont_q + 1'b1;
                end
                FIM: begin
                    saida_q    <= sat_q ? digitos_saturados() : bcd_q;
                    negativo_q <= neg_q;
                    estouro_q  <= sat_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.setseg1  = saida_q[3:0];
    assign bus.setseg2  = saida_q[7:4];
    assign bus.setseg3  = saida_q[11:8];
    assign bus.setseg4  = saida_q[15:12];
    assign bus.negativo = negativo_q;
    assign bus.estouro  = estouro_q;
    assign bus.ocupado  = ocupado;
    assign bus.pronto   = pronto_q;

endmodule

// File: doc/conversor_bcd.md
CONVERSOR_BCD -- requirements
Module: conversor_bcd

Interface
REQ-001 Parameter LARGURA, default 32: width of the signed two's-complement input word.
REQ-002 Parameter LIMITE, default 9999: largest magnitude shown without saturation.
REQ-003 clock  in  1  single system clock; all state changes on the rising edge.
REQ-004 reseta  in  1  asynchronous, active-low reset.
REQ-005 escrever  in  1  one-cycle start strobe: the result word is valid this cycle.
REQ-006 entrada  in  LARGURA  signed result word from the ALU.
REQ-007 setseg1 / setseg2 / setseg3 / setseg4  out  4 each  BCD digits (units / tens / hundreds / thousands) to the 7-segment decoders.
REQ-008 negativo  out  1  the displayed value is negative.
REQ-009 estouro  out  1  the magnitude exceeded LIMITE; digits are saturated.
REQ-010 ocupado  out  1  a conversion is in progress.
REQ-011 pronto  out  1  one-cycle pulse marking the cycle in which the outputs were updated.

Function
REQ-012 The block SHALL implement a four-state FSM: OCIOSO, CARREGA, DESLOCA, FIM.
REQ-013 In OCIOSO, escrever=1 SHALL latch entrada and move the FSM to CARREGA; escrever in any other state SHALL be ignored.
REQ-014 In CARREGA, the block SHALL compute the sign bit and the magnitude (two's-complement negation when negative) in LARGURA+1 bits, so that -2^(LARGURA-1) yields no wrap.
REQ-015 In CARREGA, a magnitude greater than LIMITE SHALL set the pending estouro flag and go directly to FIM; otherwise the FSM SHALL go to DESLOCA.
REQ-016 DESLOCA SHALL perform a shift-add-3 (double-dabble) conversion: one magnitude bit per cycle, MSB first, over exactly 14 cycles, covering the low 14 bits because 9999 < 2^14.
REQ-017 Before each shift, every 4-bit BCD digit of 5 or more SHALL have 3 added to it; a 5-bit iteration counter SHALL leave DESLOCA after its 14th shift.
REQ-018 FIM SHALL load setseg1..4, negativo and estouro together, pulse pronto for exactly one cycle, and return to OCIOSO.
REQ-019 Saturated results SHALL show digits 9,9,9,9 with estouro=1, and negativo SHALL keep the input sign.
REQ-020 A zero input SHALL give negativo=0, even though the magnitude computation also yields 0.
REQ-021 Latency: escrever sampled at edge k SHALL put pronto high in the cycle after edge k+16 (normal path) or edge k+2 (saturated path).
REQ-022 ocupado SHALL be 1 in CARREGA, DESLOCA and FIM, and 0 in OCIOSO.
REQ-023 The outputs SHALL hold their previous values throughout a conversion, so there is no intermediate flicker on the display.
REQ-024 escrever asserted in the same cycle as FIM SHALL be dropped; the producer SHALL wait for ocupado=0.

Reset
REQ-025 While reseta=0, regardless of clock: FSM=OCIOSO, setseg1..4=0, negativo=0, estouro=0, ocupado=0, pronto=0, and the counter and shift registers cleared.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion without any pronto pulse.
REQ-027 After reset is released, the first accepted escrever SHALL behave exactly as in REQ-013 to REQ-021.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, BITS_CONV=14, the LIMITE default and the saturation digit value 9.
REQ-029 One sub-module, ajusta_bcd, SHALL hold the combinational add-3 correction for a single 4-bit digit, instantiated four times.
REQ-030 No other sub-modules are allowed; the digit outputs connect directly to the existing Display7Seg instances.

Verification
REQ-031 entrada=1234, escrever pulse -> after 16 cycles pronto=1; digits 4,3,2,1 (setseg1..4); negativo=0; estouro=0.
REQ-032 entrada=-56 (0xFFFFFFC8) -> digits 6,5,0,0; negativo=1; estouro=0; pronto at +16 cycles.
REQ-033 entrada=10000, then entrada=0x80000000 -> each gives 9,9,9,9 with estouro=1 and pronto at +2 cycles; negativo=0, then negativo=1.
REQ-034 entrada=0 -> all digits 0, negativo=0; a second escrever (value 42) sent 5 cycles after the first -> ignored, and exactly one pronto pulse occurs.
REQ-035 reseta pulsed low at cycle 8 of a 9999 conversion -> all outputs 0 immediately, no pronto; a following conversion of 9999 -> 9,9,9,9 with estouro=0.
